mod_store_buffer: RTL and testbench



---
 rtl/mod_store_buffer.sv | 255 +++++++++++++++++++++++++
 tb/tb_mod_store_buffer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_store_buffer.sv
// rtl/mod_store_buffer.sv - in-order store buffer with youngest-match load lookup
//
// Purpose:
//   Holds committed stores in age order (entry 0 oldest), drains them
//   oldest-first to the data-memory port over a req/ack handshake, and
//   answers same-cycle load lookups against the registered entries.
//
// Configuration macro: STORE_BUFFER_FORWARD_EN
//   defined   : a matching load is forwarded (fwd_hit/fwd_data), never stalled.
//   undefined : fwd_hit/fwd_data are tied to 0, a matching load raises ld_stall.
//
// Ports (mod_store_buffer):
//   clock, reset            rising-edge clock, synchronous active-high reset
//   enq_valid/enq_ready     store handshake, enq_addr/enq_data payload
//   ld_valid, ld_addr       load lookup request
//   fwd_hit, fwd_data       forwarding result (data is 0 on a miss)
//   ld_stall                load must retry next cycle
//   mem_req/mem_ack         memory write handshake, mem_addr/mem_data = entry 0
//   flush, flush_done       drain request pulse / drain complete pulse
//   count                   number of occupied entries
//
// Ports (MOD_find_first_match):
//   valid_in                per-slot qualifier
//   keys_in, key_i          per-slot keys and the key searched for
//   found_o, index_o        any match, and the index of the selected match
//                           (highest index when REVERSE=1, lowest otherwise)

module MOD_find_first_match #(
  parameter int N         = 4,
  parameter int KEY_WIDTH = 16,
  parameter bit REVERSE   = 1'b0
) (
  input  logic [N-1:0]                valid_in,
  input  logic [N-1:0][KEY_WIDTH-1:0] keys_in,
  input  logic [KEY_WIDTH-1:0]        key_i,
  output logic                        found_o,
  output logic [$clog2(N)-1:0]        index_o
);

  localparam int IW = $clog2(N);

  // The last assignment in scan order wins, so scanning upward selects the
  // highest matching index and scanning downward selects the lowest.
  always_comb begin
    found_o = 1'b0;
    index_o = '0;
    if (REVERSE) begin
      for (int i = 0; i < N; i++) begin
        if (valid_in[i] && (keys_in[i] == key_i)) begin
          found_o = 1'b1;
          index_o = IW'(i);
        end
      end
    end else begin
      for (int i = N - 1; i >= 0; i--) begin
        if (valid_in[i] && (keys_in[i] == key_i)) begin
          found_o = 1'b1;
          index_o = IW'(i);
        end
      end
    end
  end

endmodule

module mod_store_buffer #(
  parameter int SIZE       = 4,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      enq_valid,
  output logic                      enq_ready,
  input  logic [ADDR_WIDTH-1:0]     enq_addr,
  input  logic [DATA_WIDTH-1:0]     enq_data,
  input  logic                      ld_valid,
  input  logic [ADDR_WIDTH-1:0]     ld_addr,
  output logic                      fwd_hit,
  output logic [DATA_WIDTH-1:0]     fwd_data,
  output logic                      ld_stall,
  output logic                      mem_req,
  output logic [ADDR_WIDTH-1:0]     mem_addr,
  output logic [DATA_WIDTH-1:0]     mem_data,
  input  logic                      mem_ack,
  input  logic                      flush,
  output logic                      flush_done,
  output logic [$clog2(SIZE+1)-1:0] count
);

  localparam int CW   = $clog2(SIZE + 1);
  localparam int IDXW = $clog2(SIZE);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    FLUSH = 2'd2
  } state_e;

  state_e                             state_q;
  logic                               mem_req_q;
  logic                               flush_done_q;
  logic [CW-1:0]                      count_q, count_d;
  logic [SIZE-1:0][ADDR_WIDTH-1:0]    addr_q, addr_d;
  logic [SIZE-1:0][DATA_WIDTH-1:0]    data_q, data_d;

  logic            enq_fire;
  logic            pop_fire;
  logic [CW-1:0]   wr_ptr;
  logic [IDXW-1:0] wr_idx;
  logic [SIZE-1:0] entry_valid;
  logic [SIZE-1:0] lookup_valid;
  logic            match_found;
  logic [IDXW-1:0] match_idx;

  assign enq_ready = (count_q < CW'(SIZE)) && (state_q != FLUSH);
  assign enq_fire  = enq_valid && enq_ready;
  assign pop_fire  = mem_req_q && mem_ack;

  // A pop in the same cycle shifts everything down one, so the new store
  // lands one slot lower. mem_req implies count_q > 0, so no underflow.
  assign wr_ptr = count_q - CW'(pop_fire);
  assign wr_idx = wr_ptr[IDXW-1:0];

  always_comb begin
    unique case ({enq_fire, pop_fire})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    addr_d = addr_q;
    data_d = data_q;
    if (pop_fire) begin
      for (int i = 0; i < SIZE - 1; i++) begin
        addr_d[i] = addr_q[i+1];
        data_d[i] = data_q[i+1];
      end
      addr_d[SIZE-1] = '0;
      data_d[SIZE-1] = '0;
    end
    if (enq_fire) begin
      addr_d[wr_idx] = enq_addr;
      data_d[wr_idx] = enq_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      count_q <= count_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  // Decisions use count_d so mem_req rises in the cycle right after a store
  // enters an empty buffer, and flush_done rises right after the final ack.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      mem_req_q    <= 1'b0;
      flush_done_q <= 1'b0;
    end else begin
      flush_done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (flush) begin
            state_q   <= FLUSH;
            mem_req_q <= (count_d != '0);
          end else if (count_d != '0) begin
            state_q   <= REQ;
            mem_req_q <= 1'b1;
          end else begin
            mem_req_q <= 1'b0;
          end
        end
        REQ: begin
          if (flush) begin
            state_q   <= FLUSH;
            mem_req_q <= (count_d != '0);
          end else if (count_d == '0) begin
            state_q   <= IDLE;
            mem_req_q <= 1'b0;
          end else begin
            mem_req_q <= 1'b1;
          end
        end
        FLUSH: begin
          // Further flush pulses are ignored; enq_ready is low so count
          // can only fall here.
          if (count_d == '0) begin
            state_q      <= IDLE;
            mem_req_q    <= 1'b0;
            flush_done_q <= 1'b1;
          end else begin
            mem_req_q <= 1'b1;
          end
        end
        default: begin
          state_q   <= IDLE;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign mem_req    = mem_req_q;
  assign mem_addr   = addr_q[0];
  assign mem_data   = data_q[0];
  assign flush_done = flush_done_q;
  assign count      = count_q;

  // Only registered entries take part: a store enqueued this cycle is not
  // visible yet, an entry being popped this cycle still is.
  always_comb begin
    entry_valid = '0;
    for (int i = 0; i < SIZE; i++) begin
      entry_valid[i] = (CW'(i) < count_q);
    end
  end

  assign lookup_valid = entry_valid & {SIZE{ld_valid}};

  // Highest valid index is the youngest store, hence REVERSE=1.
  MOD_find_first_match #(
    .N         (SIZE),
    .KEY_WIDTH (ADDR_WIDTH),
    .REVERSE   (1'b1)
  ) u_match (
    .valid_in (lookup_valid),
    .keys_in  (addr_q),
    .key_i    (ld_addr),
    .found_o  (match_found),
    .index_o  (match_idx)
  );

`ifdef STORE_BUFFER_FORWARD_EN
  assign fwd_hit  = match_found;
  assign fwd_data = match_found ? data_q[match_idx] : '0;
  assign ld_stall = 1'b0;
`else
  assign fwd_hit  = 1'b0;
  assign fwd_data = '0;
  // The selected slot is re-qualified against the live-entry mask so the
  // stall is raised only for a conflict with an occupied entry.
  assign ld_stall = match_found && entry_valid[match_idx];
`endif

endmodule

// File: tb/tb_mod_store_buffer.sv
// tb/tb_mod_store_buffer.sv - table-driven bench for mod_store_buffer

module tb_mod_store_buffer;

  localparam int SIZE = 4;
  localparam int AW   = 16;
  localparam int DW   = 16;
  localparam int CW   = $clog2(SIZE + 1);

  logic          clock = 1'b0;
  logic          reset;
  logic          enq_valid;
  logic          enq_ready;
  logic [AW-1:0] enq_addr;
  logic [DW-1:0] enq_data;
  logic          ld_valid;
  logic [AW-1:0] ld_addr;
  logic          fwd_hit;
  logic [DW-1:0] fwd_data;
  logic          ld_stall;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic          mem_ack;
  logic          flush;
  logic          flush_done;
  logic [CW-1:0] count;

  always #5 clock = ~clock;

  mod_store_buffer #(
    .SIZE       (SIZE),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .enq_valid  (enq_valid),
    .enq_ready  (enq_ready),
    .enq_addr   (enq_addr),
    .enq_data   (enq_data),
    .ld_valid   (ld_valid),
    .ld_addr    (ld_addr),
    .fwd_hit    (fwd_hit),
    .fwd_data   (fwd_data),
    .ld_stall   (ld_stall),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .mem_ack    (mem_ack),
    .flush      (flush),
    .flush_done (flush_done),
    .count      (count)
  );

  typedef struct {
    logic          ev;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic          lv;
    logic [AW-1:0] la;
    logic          ack;
    logic          fl;
    int            cnt;
    logic          rdy;
    logic          req;
    logic [AW-1:0] maddr;
    logic [DW-1:0] mdata;
    logic          match;
    logic [DW-1:0] mdat;
    logic          fdone;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  function automatic vec_t mk(input int ev, input int ea, input int ed,
                              input int lv, input int la, input int ack,
                              input int fl, input int cnt, input int rdy,
                              input int req, input int maddr, input int mdata,
                              input int match, input int mdat, input int fdone);
    vec_t v;
    v.ev = ev[0]; v.ea = ea[AW-1:0]; v.ed = ed[DW-1:0];
    v.lv = lv[0]; v.la = la[AW-1:0]; v.ack = ack[0]; v.fl = fl[0];
    v.cnt = cnt; v.rdy = rdy[0]; v.req = req[0];
    v.maddr = maddr[AW-1:0]; v.mdata = mdata[DW-1:0];
    v.match = match[0]; v.mdat = mdat[DW-1:0]; v.fdone = fdone[0];
    return v;
  endfunction

  task automatic chk(input string nm, input int row, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %0h expected %0h", nm, row, act, exp);
    end
  endtask

  task automatic idle_inputs();
    enq_valid = 1'b0; enq_addr = '0; enq_data = '0;
    ld_valid = 1'b0; ld_addr = '0; mem_ack = 1'b0; flush = 1'b0;
  endtask

  initial begin
    logic          e_hit;
    logic [DW-1:0] e_fd;
    logic          e_st;
    logic [AW-1:0] got[$];
    int            last_pop;
    int            fd_cnt;
    int            fd_cyc;
    int            writes;

    reset = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;

    //        ev  ea     ed      lv la     ack fl  cnt rdy req maddr mdata   m  mdat    fd
    vecs.push_back(mk(0, 0,     0,      0, 0,     0, 0,  0, 1, 0, 0,    0,      0, 0,      0));
    vecs.push_back(mk(1, 'h10,  'hAAAA, 1, 'h10,  0, 0,  0, 1, 0, 0,    0,      0, 0,      0));
    vecs.push_back(mk(0, 0,     0,      1, 'h10,  0, 0,  1, 1, 1, 'h10, 'hAAAA, 1, 'hAAAA, 0));
    vecs.push_back(mk(0, 0,     0,      0, 'h10,  0, 0,  1, 1, 1, 'h10, 'hAAAA, 0, 0,      0));
    vecs.push_back(mk(0, 0,     0,      1, 'h10,  1, 0,  1, 1, 1, 'h10, 'hAAAA, 1, 'hAAAA, 0));
    vecs.push_back(mk(0, 0,     0,      1, 'h10,  0, 0,  0, 1, 0, 0,    0,      0, 0,      0));
    vecs.push_back(mk(1, 'h20,  'h1111, 0, 0,     0, 0,  0, 1, 0, 0,    0,      0, 0,      0));
    vecs.push_back(mk(1, 'h20,  'h2222, 1, 'h20,  0, 0,  1, 1, 1, 'h20, 'h1111, 1, 'h1111, 0));
    vecs.push_back(mk(0, 0,     0,      1, 'h20,  0, 0,  2, 1, 1, 'h20, 'h1111, 1, 'h2222, 0));
    vecs.push_back(mk(0, 0,     0,      1, 'h30,  0, 0,  2, 1, 1, 'h20, 'h1111, 0, 0,      0));
    vecs.push_back(mk(1, 'h30,  'h3333, 1, 'h30,  0, 0,  2, 1, 1, 'h20, 'h1111, 0, 0,      0));
    vecs.push_back(mk(1, 'h40,  'h4444, 1, 'h30,  0, 0,  3, 1, 1, 'h20, 'h1111, 1, 'h3333, 0));
    vecs.push_back(mk(0, 0,     0,      1, 'h40,  0, 0,  4, 0, 1, 'h20, 'h1111, 1, 'h4444, 0));
    vecs.push_back(mk(1, 'hFF,  'h5555, 1, 'h20,  1, 0,  4, 0, 1, 'h20, 'h1111, 1, 'h2222, 0));
    vecs.push_back(mk(1, 'hFF,  'h5555, 1, 'hFF,  0, 0,  3, 1, 1, 'h20, 'h2222, 0, 0,      0));
    vecs.push_back(mk(0, 0,     0,      1, 'hFF,  0, 0,  4, 0, 1, 'h20, 'h2222, 1, 'h5555, 0));
    vecs.push_back(mk(0, 0,     0,      0, 0,     1, 0,  4, 0, 1, 'h20, 'h2222, 0, 0,      0));
    vecs.push_back(mk(0, 0,     0,      0, 0,     0, 1,  3, 1, 1, 'h30, 'h3333, 0, 0,      0));
    vecs.push_back(mk(0, 0,     0,      1, 'hFF,  1, 0,  3, 0, 1, 'h30, 'h3333, 1, 'h5555, 0));
    vecs.push_back(mk(0, 0,     0,      0, 0,     1, 1,  2, 0, 1, 'h40, 'h4444, 0, 0,      0));
    vecs.push_back(mk(1, 'h123, 'h9999, 0, 0,     1, 0,  1, 0, 1, 'hFF, 'h5555, 0, 0,      0));
    vecs.push_back(mk(0, 0,     0,      1, 'h123, 1, 0,  0, 1, 0, 0,    0,      0, 0,      1));
    vecs.push_back(mk(0, 0,     0,      0, 0,     0, 0,  0, 1, 0, 0,    0,      0, 0,      0));
    vecs.push_back(mk(0, 0,     0,      0, 0,     0, 1,  0, 1, 0, 0,    0,      0, 0,      0));
    vecs.push_back(mk(0, 0,     0,      0, 0,     0, 0,  0, 0, 0, 0,    0,      0, 0,      0));
    vecs.push_back(mk(0, 0,     0,      0, 0,     0, 0,  0, 1, 0, 0,    0,      0, 0,      1));
    vecs.push_back(mk(0, 0,     0,      0, 0,     0, 0,  0, 1, 0, 0,    0,      0, 0,      0));
    vecs.push_back(mk(1, 'h40,  'h7777, 1, 'h40,  0, 0,  0, 1, 0, 0,    0,      0, 0,      0));
    vecs.push_back(mk(0, 0,     0,      1, 'h40,  0, 0,  1, 1, 1, 'h40, 'h7777, 1, 'h7777, 0));
    vecs.push_back(mk(0, 0,     0,      1, 'h40,  1, 0,  1, 1, 1, 'h40, 'h7777, 1, 'h7777, 0));
    vecs.push_back(mk(0, 0,     0,      1, 'h40,  0, 0,  0, 1, 0, 0,    0,      0, 0,      0));

    foreach (vecs[r]) begin
      @(negedge clock);
      enq_valid = vecs[r].ev; enq_addr = vecs[r].ea; enq_data = vecs[r].ed;
      ld_valid = vecs[r].lv; ld_addr = vecs[r].la;
      mem_ack = vecs[r].ack; flush = vecs[r].fl;
      #1;
`ifdef STORE_BUFFER_FORWARD_EN
      e_hit = vecs[r].match;
      e_fd  = vecs[r].match ? vecs[r].mdat : '0;
      e_st  = 1'b0;
`else
      e_hit = 1'b0;
      e_fd  = '0;
      e_st  = vecs[r].match;
`endif
      chk("count",      r, 32'(count),      32'(vecs[r].cnt));
      chk("enq_ready",  r, 32'(enq_ready),  32'(vecs[r].rdy));
      chk("mem_req",    r, 32'(mem_req),    32'(vecs[r].req));
      chk("mem_addr",   r, 32'(mem_addr),   32'(vecs[r].maddr));
      chk("mem_data",   r, 32'(mem_data),   32'(vecs[r].mdata));
      chk("flush_done", r, 32'(flush_done), 32'(vecs[r].fdone));
      chk("fwd_hit",    r, 32'(fwd_hit),    32'(e_hit));
      chk("fwd_data",   r, 32'(fwd_data),   32'(e_fd));
      chk("ld_stall",   r, 32'(ld_stall),   32'(e_st));
    end

    // Back-to-back flush drain: three entries, ack held high.
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      idle_inputs();
      enq_valid = 1'b1; enq_addr = AW'(16'h00A0 + k); enq_data = DW'(16'hB000 + k);
    end
    last_pop = -100; fd_cnt = 0; fd_cyc = -1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clock);
      idle_inputs();
      flush = (cyc == 0);
      mem_ack = 1'b1;
      #1;
      if (cyc == 0) chk("seqA_count", 100, 32'(count), 32'd3);
      if (cyc > 0 && mem_req) chk("seqA_enq_ready", 100 + cyc, 32'(enq_ready), 32'd0);
      if (mem_req && mem_ack) begin
        got.push_back(mem_addr);
        last_pop = cyc;
      end
      if (flush_done) begin
        fd_cnt++;
        fd_cyc = cyc;
      end
    end
    chk("seqA_writes", 100, 32'(got.size()), 32'd3);
    foreach (got[i]) chk("seqA_order", 100 + i, 32'(got[i]), 32'h00A0 + 32'(i));
    chk("seqA_done_count", 100, 32'(fd_cnt), 32'd1);
    chk("seqA_done_cycle", 100, 32'(fd_cyc), 32'(last_pop + 1));

    // Reset while a request is outstanding with two entries queued.
    for (int k = 0; k < 2; k++) begin
      @(negedge clock);
      idle_inputs();
      enq_valid = 1'b1; enq_addr = AW'(16'h00B0 + k); enq_data = DW'(16'hC000 + k);
    end
    @(negedge clock);
    idle_inputs();
    #1;
    chk("seqB_req_before", 200, 32'(mem_req), 32'd1);
    chk("seqB_count_before", 200, 32'(count), 32'd2);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("seqB_count", 201, 32'(count), 32'd0);
    chk("seqB_req", 201, 32'(mem_req), 32'd0);
    chk("seqB_addr", 201, 32'(mem_addr), 32'd0);
    chk("seqB_ready", 201, 32'(enq_ready), 32'd1);
    writes = 0;
    for (int cyc = 0; cyc < 4; cyc++) begin
      @(negedge clock);
      mem_ack = 1'b1;
      #1;
      if (mem_req && mem_ack) writes++;
    end
    chk("seqB_no_write", 202, 32'(writes), 32'd0);
    idle_inputs();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
